switch_alloc: RTL

Switch allocator for the torus router: collects route-computed requests from the seven input ports (inject plus six link directions), grants at most one input per output direction per cycle with per-output round-robin fairness, and gates link outputs on downstream credit. Sits between the per-port route computation stages (which supply a 3-bit direction code per flit) and the crossbar, whose select lines it drives.

---
 rtl/router_pkg.sv | 16 +
 rtl/switch_alloc_rr_arbiter.sv | 38 +++
 rtl/switch_alloc.sv | 114 +++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// router_pkg: direction codes and sizing defaults shared by the torus router blocks.
package router_pkg;
    typedef enum logic [2:0] {
        DIR_INJECT = 3'd0,
        DIR_XPOS   = 3'd1,
        DIR_YPOS   = 3'd2,
        DIR_ZPOS   = 3'd3,
        DIR_XNEG   = 3'd4,
        DIR_YNEG   = 3'd5,
        DIR_ZNEG   = 3'd6,
        DIR_EJECT  = 3'd7
    } dir_e;
    localparam int N_IN_DEFAULT         = 7;
    localparam int N_PORTS              = 8;
    localparam int CREDIT_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/switch_alloc_rr_arbiter.sv
// rr_arbiter: picks the first request at or after a registered pointer, cyclically;
// the pointer moves just past each winner.
module rr_arbiter #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         avail,
    output logic [N-1:0] gnt,
    output logic [2:0]   idx
);
    logic [2:0] ptr;
    logic [2:0] j;
    logic       found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = 3'((int'(ptr) + k) % N);
            if (avail && !found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= '0;
        else if (found)
            ptr <= (int'(idx) == N - 1) ? 3'd0 : idx + 3'd1;
    end
endmodule

// File: rtl/switch_alloc.sv
// switch_alloc: per-output round-robin switch allocator for the torus router.
// Link credit tracking is compiled in with SWITCH_ALLOC_CREDIT_EN; otherwise links are always available.
module switch_alloc
    import router_pkg::*;
#(
    parameter int N_IN         = N_IN_DEFAULT,
    parameter int CREDIT_DEPTH = CREDIT_DEPTH_DEFAULT,
    parameter int CW           = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_IN-1:0]        req_valid,
    input  logic [3*N_IN-1:0]      req_dir,
    input  logic [5:0]             credit_return,
    input  logic                   eject_ready,
    output logic [N_IN-1:0]        grant,
    output logic [N_PORTS-1:0]     out_valid,
    output logic [3*N_PORTS-1:0]   out_sel,
    output logic                   err_credit
);
    logic [N_IN-1:0]    elig [N_PORTS];
    logic [N_IN-1:0]    gnt  [N_PORTS];
    logic [2:0]         idx  [N_PORTS];
    logic [N_PORTS-1:0] avail;
    logic [6:1]         link_ok;
    logic [N_IN-1:0]    grant_next;

    // A held request that is being granted this cycle must not win again.
    always_comb begin
        for (int d = 0; d < N_PORTS; d++)
            for (int i = 0; i < N_IN; i++)
                elig[d][i] = d != int'(DIR_INJECT) && req_valid[i] && !grant[i]
                             && int'(req_dir[3*i +: 3]) == d;
    end

    assign avail = {eject_ready, link_ok, 1'b0};

    genvar d;
    generate
        for (d = 0; d < N_PORTS; d++) begin : g_out
            if (d == 0) begin : g_inject
                assign gnt[d] = '0;
                assign idx[d] = '0;
            end else begin : g_arb
                rr_arbiter #(.N(N_IN)) u_arb (
                    .clk   (clk),
                    .rst   (rst),
                    .req   (elig[d]),
                    .avail (avail[d]),
                    .gnt   (gnt[d]),
                    .idx   (idx[d])
                );
            end
        end
    endgenerate

    always_comb begin
        grant_next = '0;
        for (int k = 0; k < N_PORTS; k++)
            grant_next = grant_next | gnt[k];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant     <= '0;
            out_valid <= '0;
            out_sel   <= '0;
        end else begin
            grant <= grant_next;
            for (int k = 0; k < N_PORTS; k++) begin
                out_valid[k]       <= |gnt[k];
                out_sel[3*k +: 3]  <= idx[k];
            end
        end
    end

`ifdef SWITCH_ALLOC_CREDIT_EN
    logic [CW-1:0] credit [1:6];
    logic [6:1]    used;
    logic [6:1]    full;

    always_comb begin
        used    = '0;
        full    = '0;
        link_ok = '0;
        for (int k = 1; k <= 6; k++) begin
            used[k]    = |gnt[k];
            full[k]    = credit[k] == CW'(CREDIT_DEPTH);
            link_ok[k] = credit[k] != '0;
        end
    end

    // A grant and a return on the same edge cancel; a return into a full counter is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= 6; k++)
                credit[k] <= CW'(CREDIT_DEPTH);
            err_credit <= 1'b0;
        end else begin
            for (int k = 1; k <= 6; k++)
                if (used[k] != credit_return[k-1])
                    credit[k] <= used[k] ? credit[k] - CW'(1)
                               : (full[k] ? credit[k] : credit[k] + CW'(1));
            if (|(credit_return & ~used & full))
                err_credit <= 1'b1;
        end
    end
`else
    logic unused_credit;
    assign unused_credit = ^{credit_return, CW[0], CREDIT_DEPTH[0]};
    assign link_ok       = '1;
    assign err_credit    = 1'b0;
`endif
endmodule
